// File: rtl/vreg_pkg.sv
// Purpose: shared constants, types and helpers for the vector register write-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package vreg_pkg;

    localparam int REGSIZE    = 16;
    localparam int REGSIZEINT = 5;
    localparam int DATAW      = 128;
    localparam int IDXW       = $clog2(REGSIZE);

    typedef logic [REGSIZEINT-1:0] vreg_addr_t;
    typedef logic [DATAW-1:0]      vreg_data_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LD  = 1'b1
    } wb_src_e;

    // Winning write-back request after arbitration.
    typedef struct packed {
        vreg_addr_t rd;
        vreg_data_t data;
    } wb_req_t;

    // The address field is one bit wider than the register index, so
    // addresses at or above REGSIZE are representable and must be filtered.
    function automatic logic addr_ok(input vreg_addr_t a);
        return a < vreg_addr_t'(REGSIZE);
    endfunction

endpackage

// File: rtl/vreg_scoreboard.sv
// Purpose: busy bit per vector register with one set port, one clear port and three lookups.
// Latency: set/clear take effect at the next edge; lookups are combinational.
// Backpressure: none; out-of-range addresses are ignored on write and read as not busy.
module vreg_scoreboard
    import vreg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REGSIZEINT-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REGSIZEINT-1:0] clr_addr,
    input  logic [REGSIZEINT-1:0] rd_addr0,
    input  logic [REGSIZEINT-1:0] rd_addr1,
    input  logic [REGSIZEINT-1:0] rd_addr2,
    output logic                  hit0,
    output logic                  hit1,
    output logic                  hit2,
    output logic                  empty
);

    logic [REGSIZE-1:0] busy;
    logic [REGSIZE-1:0] busy_nxt;

    assign hit0  = addr_ok(rd_addr0) & busy[rd_addr0[IDXW-1:0]];
    assign hit1  = addr_ok(rd_addr1) & busy[rd_addr1[IDXW-1:0]];
    assign hit2  = addr_ok(rd_addr2) & busy[rd_addr2[IDXW-1:0]];
    assign empty = (busy == '0);

    // Next busy vector: clear first, then set, so a same-register set wins.
    always_comb begin
        busy_nxt = busy;
        if (clr_en && addr_ok(clr_addr)) begin
            busy_nxt[clr_addr[IDXW-1:0]] = 1'b0;
        end
        if (set_en && addr_ok(set_addr)) begin
            busy_nxt[set_addr[IDXW-1:0]] = 1'b1;
        end
    end

    // Busy vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/vreg_wb_sched.sv
// Purpose: arbitrate ALU/load write-back onto the single RF write port and stall issue on RAW/WAW.
// Latency: 1 cycle from handshake to rf_we3; stall and ready are combinational.
// Backpressure: round-robin ready, so a requester held valid waits at most one cycle.
module vreg_wb_sched
    import vreg_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REGSIZEINT-1:0] alu_rd,
    input  logic [DATAW-1:0]      alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REGSIZEINT-1:0] ld_rd,
    input  logic [DATAW-1:0]      ld_data,
    input  logic                  iss_valid,
    input  logic                  iss_wr,
    input  logic [REGSIZEINT-1:0] iss_rs1,
    input  logic [REGSIZEINT-1:0] iss_rs2,
    input  logic [REGSIZEINT-1:0] iss_rd,
    output logic                  iss_stall,
    output logic                  rf_we3,
    output logic [REGSIZEINT-1:0] rf_ra3,
    output logic [DATAW-1:0]      rf_wd3,
    output logic                  idle
);

    wb_src_e last_src;
    wb_req_t win;
    logic    hs;
    logic    hit_rs1, hit_rs2, hit_rd;
    logic    sb_empty;
    logic    iss_acc;

    // Round-robin grant: ALU wins unless the load unit is also valid and the ALU went last.
    always_comb begin
        alu_ready = alu_valid & (~ld_valid | (last_src == WB_LD));
        ld_ready  = ld_valid & ~alu_ready;
        win.rd    = ld_ready ? ld_rd   : alu_rd;
        win.data  = ld_ready ? ld_data : alu_data;
    end

    assign hs = alu_ready | ld_ready;

    // Remember who was granted last; reset value gives the ALU first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_src <= WB_LD;
        end else if (alu_ready) begin
            last_src <= WB_ALU;
        end else if (ld_ready) begin
            last_src <= WB_LD;
        end
    end

    // Write-port register; out-of-range destinations complete the handshake but never write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we3 <= 1'b0;
            rf_ra3 <= '0;
            rf_wd3 <= '0;
        end else begin
            rf_we3 <= hs & addr_ok(win.rd);
            if (hs && addr_ok(win.rd)) begin
                rf_ra3 <= win.rd;
                rf_wd3 <= win.data;
            end
        end
    end

    // No bypass: a source stays stalled during its write cycle and frees up the cycle after.
    assign iss_stall = iss_valid & (hit_rs1 | hit_rs2 | (iss_wr & hit_rd));
    assign iss_acc   = iss_valid & iss_wr & ~iss_stall;
    assign idle      = sb_empty & ~rf_we3;

    vreg_scoreboard u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (iss_acc),
        .set_addr (iss_rd),
        .clr_en   (rf_we3),
        .clr_addr (rf_ra3),
        .rd_addr0 (iss_rs1),
        .rd_addr1 (iss_rs2),
        .rd_addr2 (iss_rd),
        .hit0     (hit_rs1),
        .hit1     (hit_rs2),
        .hit2     (hit_rd),
        .empty    (sb_empty)
    );

endmodule

// File: tb/tb_vreg_wb_sched.sv
// Purpose: directed self-checking bench for the vector write-back scheduler.
// Latency: checks combinational outputs mid-cycle, registered outputs 1 time unit after the edge.
// Backpressure: exercises round-robin grants under simultaneous requests.
module tb_vreg_wb_sched;

    logic         clk;
    logic         rst_n;
    logic         alu_valid, alu_ready;
    logic [4:0]   alu_rd;
    logic [127:0] alu_data;
    logic         ld_valid, ld_ready;
    logic [4:0]   ld_rd;
    logic [127:0] ld_data;
    logic         iss_valid, iss_wr;
    logic [4:0]   iss_rs1, iss_rs2, iss_rd;
    logic         iss_stall;
    logic         rf_we3;
    logic [4:0]   rf_ra3;
    logic [127:0] rf_wd3;
    logic         idle;

    int nvec = 0;
    int nerr = 0;

    localparam logic [127:0] DA5 = {16{8'hA5}};
    localparam logic [127:0] D1  = {16{8'h11}};
    localparam logic [127:0] D2  = {16{8'h22}};
    localparam logic [127:0] D3  = {16{8'h33}};
    localparam logic [127:0] D4  = {16{8'h44}};
    localparam logic [127:0] D5  = {16{8'h55}};
    localparam logic [127:0] D6  = {16{8'h66}};

    vreg_wb_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .iss_valid (iss_valid),
        .iss_wr    (iss_wr),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_stall (iss_stall),
        .rf_we3    (rf_we3),
        .rf_ra3    (rf_ra3),
        .rf_wd3    (rf_wd3),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0;  ld_rd = '0;  ld_data = '0;
        iss_valid = 1'b0; iss_wr = 1'b0;
        iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;

        // Reset state
        tick(); tick();
        chk("rst_we3", rf_we3, 0);
        chk("rst_ra3", rf_ra3, 0);
        chk("rst_wd3", rf_wd3, 0);
        chk("rst_idle", idle, 1);
        chk("rst_stall", iss_stall, 0);
        chk("rst_alu_rdy", alu_ready, 0);
        chk("rst_ld_rdy", ld_ready, 0);
        rst_n = 1'b1;
        tick();

        // Single ALU write, latency 1
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = DA5;
        #1;
        chk("t1_alu_rdy", alu_ready, 1);
        chk("t1_ld_rdy", ld_ready, 0);
        tick();
        alu_valid = 1'b0;
        chk("t1_we3", rf_we3, 1);
        chk("t1_ra3", rf_ra3, 3);
        chk("t1_wd3", rf_wd3, DA5);
        chk("t1_idle_busy", idle, 0);
        tick();
        chk("t1_we3_off", rf_we3, 0);
        chk("t1_ra3_hold", rf_ra3, 3);
        chk("t1_wd3_hold", rf_wd3, DA5);
        chk("t1_idle", idle, 1);

        // Reset pulse so the round-robin pointer favours the ALU again
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();

        // Both requesters valid for 4 cycles: ALU, LD, ALU, LD
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = D1;
        ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = D2;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_alu_rdy", alu_ready, (k % 2) == 0);
            chk("rr_ld_rdy", ld_ready, (k % 2) == 1);
            tick();
            chk("rr_we3", rf_we3, 1);
            chk("rr_ra3", rf_ra3, ((k % 2) == 0) ? 1 : 2);
            chk("rr_wd3", rf_wd3, ((k % 2) == 0) ? D1 : D2);
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        tick();
        chk("rr_we3_off", rf_we3, 0);

        // RAW hazard on reg 5
        iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd5; iss_rs1 = '0; iss_rs2 = '0;
        #1;
        chk("raw_acc_stall", iss_stall, 0);
        tick();
        iss_wr = 1'b0; iss_rs1 = 5'd5;
        #1;
        chk("raw_rs1_stall", iss_stall, 1);
        chk("raw_idle", idle, 0);
        iss_rs1 = '0; iss_rs2 = 5'd5;
        #1;
        chk("raw_rs2_stall", iss_stall, 1);
        iss_rs2 = '0; iss_wr = 1'b1; iss_rd = 5'd5;
        #1;
        chk("waw_stall", iss_stall, 1);
        iss_wr = 1'b0; iss_rd = '0; iss_rs1 = 5'd5;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = D3;
        #1;
        chk("raw_wb_rdy", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        #1;
        chk("raw_wb_we3", rf_we3, 1);
        chk("raw_wb_ra3", rf_ra3, 5);
        chk("raw_nobypass", iss_stall, 1);
        tick();
        chk("raw_released", iss_stall, 0);
        chk("raw_idle_back", idle, 1);
        iss_valid = 1'b0;

        // Same-cycle write to reg 7 and issue with rd 7: set wins
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = D4;
        #1;
        chk("sw_alu_rdy", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd7; iss_rs1 = '0; iss_rs2 = '0;
        #1;
        chk("sw_we3", rf_we3, 1);
        chk("sw_ra3", rf_ra3, 7);
        chk("sw_acc_stall", iss_stall, 0);
        tick();
        iss_wr = 1'b0; iss_rs1 = 5'd7;
        #1;
        chk("sw_busy7_stall", iss_stall, 1);
        chk("sw_idle", idle, 0);
        alu_valid = 1'b1;
        tick();
        alu_valid = 1'b0;
        tick();
        chk("sw_cleared", iss_stall, 0);
        chk("sw_idle_back", idle, 1);
        iss_valid = 1'b0;

        // Out-of-range load destination and issue addresses
        ld_valid = 1'b1; ld_rd = 5'd20; ld_data = D5;
        iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd20; iss_rs1 = 5'd20; iss_rs2 = 5'd20;
        #1;
        chk("oor_ld_rdy", ld_ready, 1);
        chk("oor_alu_rdy", alu_ready, 0);
        chk("oor_stall", iss_stall, 0);
        tick();
        ld_valid = 1'b0; iss_valid = 1'b0;
        chk("oor_we3", rf_we3, 0);
        chk("oor_idle", idle, 1);

        // Reset mid-operation with busy={4,9} and a write in flight
        iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 5'd4; iss_rs1 = '0; iss_rs2 = '0;
        tick();
        iss_rd = 5'd9;
        tick();
        iss_wr = 1'b0; iss_rs1 = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = D6;
        #1;
        chk("mr_stall_pre", iss_stall, 1);
        chk("mr_alu_rdy", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        chk("mr_we3_pre", rf_we3, 1);
        chk("mr_idle_pre", idle, 0);
        rst_n = 1'b0;
        #1;
        chk("mr_we3", rf_we3, 0);
        chk("mr_ra3", rf_ra3, 0);
        chk("mr_wd3", rf_wd3, 0);
        chk("mr_idle", idle, 1);
        chk("mr_stall", iss_stall, 0);
        tick();
        rst_n = 1'b1;
        iss_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/vreg_wb_sched.md
Name: vreg_wb_sched

Overview:
- Write-back scheduler and hazard scoreboard for the 16-entry x 128-bit vector register file (single write port we3/ra3/wd3, two async read ports).
- Arbitrates the vector ALU and vector load unit for the one write port.
- Registers the winning write into the register file.
- Tracks pending destination registers and stalls vector issue on RAW/WAW hazards.
- Sits between issue stage, execution units and the vector register file.

Parameters:
- REGSIZE, 16, number of vector registers.
- REGSIZEINT, 5, register address width.
- DATAW, 128, vector write-data width (16 lanes x 8 bit).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU write-back request.
- alu_ready  out  1  ALU request granted this cycle.
- alu_rd  in  REGSIZEINT  ALU destination register.
- alu_data  in  DATAW  ALU result.
- ld_valid  in  1  load-unit write-back request.
- ld_ready  out  1  load request granted this cycle.
- ld_rd  in  REGSIZEINT  load destination register.
- ld_data  in  DATAW  load data.
- iss_valid  in  1  vector instruction presented at issue.
- iss_wr  in  1  instruction writes a vector register.
- iss_rs1, iss_rs2, iss_rd  in  REGSIZEINT  source and destination registers.
- iss_stall  out  1  issue must hold the instruction.
- rf_we3  out  1  register-file write enable.
- rf_ra3  out  REGSIZEINT  register-file write address.
- rf_wd3  out  DATAW  register-file write data.
- idle  out  1  no pending writes and no write in flight.

Behaviour:
- Reset (async, rst_n=0):
  - rf_we3=0, rf_ra3=0, rf_wd3=0.
  - Busy vector = 0; round-robin pointer favours ALU.
  - idle=1.
  - In-flight requests are discarded; requesters re-present after reset.
- Arbitration:
  - alu_ready/ld_ready are combinational; at most one is asserted per cycle.
  - Only one requester valid: it is granted.
  - Both valid: the requester not granted last wins.
  - A continuously valid requester waits at most 1 cycle.
  - Requesters hold valid, rd and data stable until ready; handshake = valid & ready.
- Write pipeline, latency 1:
  - A handshake at cycle N gives rf_we3=1, rf_ra3=rd, rf_wd3=data in cycle N+1; the register file updates at the end of N+1.
  - No handshake: rf_we3=0; rf_ra3/rf_wd3 hold their previous values.
  - rd >= REGSIZE: handshake completes, rf_we3 stays 0, scoreboard unchanged.
- Scoreboard busy[REGSIZE-1:0]:
  - Issue accept = iss_valid & iss_wr & ~iss_stall; it sets busy[iss_rd] at the clock edge.
  - rf_we3=1 clears busy[rf_ra3] at the clock edge.
  - Set and clear of the same register in the same cycle: set wins.
  - Out-of-range addresses never set a bit; reads of out-of-range bits return 0.
- Stall (combinational):
  - iss_stall = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | (iss_wr & busy[iss_rd])).
  - No bypass: while rf_we3 is writing a source register, stall stays high that cycle and drops the next cycle.
- idle = (busy==0) & ~rf_we3.

Decomposition:
- Shared package vreg_pkg:
  - REGSIZE, REGSIZEINT, DATAW constants.
  - typedef vreg_addr_t (logic [REGSIZEINT-1:0]).
  - typedef vreg_data_t (logic [DATAW-1:0]).
  - typedef wb_src_e {WB_ALU, WB_LD}.
- One natural sub-module, vreg_scoreboard: busy vector with set/clear ports and three combinational lookups.
- The arbiter and write register stay in the top module.

Test Plan:
- Reset, then alu_valid=1, alu_rd=3, alu_data=128'hA5.. for one cycle -> alu_ready=1 same cycle; next cycle rf_we3=1, rf_ra3=3, rf_wd3=128'hA5..; following cycle rf_we3=0.
- alu_valid and ld_valid held high for 4 cycles (rd 1 and 2) -> grants ALU, LD, ALU, LD; rf_ra3 sequence 1,2,1,2 with 1-cycle lag.
- Issue accept with iss_rd=5 -> busy[5]=1, idle=0.
  - Next instruction iss_rs1=5 -> iss_stall=1 until the cycle after rf_we3 with rf_ra3=5, then 0.
- Same cycle: rf_we3 to reg 7 and issue accept with iss_rd=7 -> busy[7] remains 1.
- ld_rd=20 handshake -> ld_ready=1, rf_we3 stays 0, busy unchanged.
- Reset asserted mid-operation with busy={4,9} and rf_we3=1 -> all outputs reset immediately, iss_stall=0, idle=1.
